branch_outcome_tracker: RTL and testbench

Tracks every in-flight branch prediction from issue to resolution and generates the predictor update stream. Each cycle the tournament predictor answers a query, this block records the query index and the predicted direction in an ordered buffer. When execute resolves the oldest branch, the block compares the outcome with the stored prediction and drives the registered update/rollback signals back into the predictor bus. On a mispredict it flushes all younger entries.

---
 rtl/branch_outcome_tracker_pkg.sv | 18 +
 rtl/branch_outcome_tracker_fifo.sv | 67 ++++++
 rtl/branch_outcome_tracker.sv | 87 ++++++++
 tb/tb_branch_outcome_tracker.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/branch_outcome_tracker_pkg.sv
// Shared prediction types and constants for the branch outcome tracker.
// Contents:
//   GLOBAL_HIST_LEN          - default width of a predictor index
//   MAX_ROLLBACK_CYCLES_INCL - worst-case number of unresolved branches
//   TRACKER_DEPTH            - default tracker capacity
//   tracked_branch_t         - one in-flight branch record at the default index width
package branch_outcome_tracker_pkg;

   localparam int unsigned GLOBAL_HIST_LEN          = 8;
   localparam int unsigned MAX_ROLLBACK_CYCLES_INCL = 8;
   localparam int unsigned TRACKER_DEPTH            = MAX_ROLLBACK_CYCLES_INCL;

   typedef struct packed {
      logic [GLOBAL_HIST_LEN-1:0] index;
      logic                       predicted_take;
   } tracked_branch_t;

endpackage

// File: rtl/branch_outcome_tracker_fifo.sv
// Parameterised circular buffer used by branch_outcome_tracker.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   push, push_data     - write push_data at the tail (dropped when full unless popping)
//   pop                 - retire the head entry (ignored when empty)
//   clear               - empty the buffer; wins over push and pop
//   head_data           - oldest entry
//   count, full, empty  - occupancy, all derived from the registered count
module tracker_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 9,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             clear,
   output logic [WIDTH-1:0] head_data,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] head_q, tail_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push, do_pop;

   // Explicit wrap so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full      = (count_q == CNT_W'(DEPTH));
   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign head_data = mem[head_q];
   // A simultaneous pop frees the slot, so pushing while full is legal then.
   assign do_push   = push && (!full || pop);
   assign do_pop    = pop && !empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (clear) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) tail_q <= wrap_inc(tail_q);
         if (do_pop)  head_q <= wrap_inc(head_q);
         if (do_push && !do_pop)      count_q <= count_q + 1'b1;
         else if (do_pop && !do_push) count_q <= count_q - 1'b1;
      end
   end

   // Storage needs no reset; contents are qualified by count.
   always_ff @(posedge clk) begin
      if (do_push && !clear) mem[tail_q] <= push_data;
   end

endmodule

// File: rtl/branch_outcome_tracker.sv
// Tracks in-flight branch predictions in order and emits the predictor update stream.
// Ports:
//   clk, reset                        - clock, asynchronous active-high reset
//   is_stalling                       - front-end stall, blocks pushes only
//   query_valid, query_index,
//   predicted_take                    - prediction to record
//   resolve_valid, resolve_taken      - oldest branch resolved, actual direction
//   update_enable, update_index,
//   update_taken, update_is_rollback  - registered one-cycle predictor update
//   flush                             - registered mispredict flush pulse
//   count, full, empty                - occupancy
//   error                             - sticky: push while full or resolve while empty
module branch_outcome_tracker
   import branch_outcome_tracker_pkg::*;
#(
   parameter int unsigned DEPTH     = TRACKER_DEPTH,
   parameter int unsigned INDEX_LEN = GLOBAL_HIST_LEN,
   localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 is_stalling,
   input  logic                 query_valid,
   input  logic [INDEX_LEN-1:0] query_index,
   input  logic                 predicted_take,
   input  logic                 resolve_valid,
   input  logic                 resolve_taken,
   output logic                 update_enable,
   output logic [INDEX_LEN-1:0] update_index,
   output logic                 update_taken,
   output logic                 update_is_rollback,
   output logic                 flush,
   output logic [CNT_W-1:0]     count,
   output logic                 full,
   output logic                 empty,
   output logic                 error
);

   typedef struct packed {
      logic [INDEX_LEN-1:0] index;
      logic                 predicted_take;
   } entry_t;

   entry_t push_entry, head_entry;
   logic   push, pop, mispredict;

   assign push       = query_valid && !is_stalling;
   assign pop        = resolve_valid && !empty;
   assign mispredict = pop && (head_entry.predicted_take != resolve_taken);
   assign push_entry = '{index: query_index, predicted_take: predicted_take};

   // A mispredict clears the buffer, which also discards a same-cycle (younger) push.
   tracker_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(entry_t))
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .clear     (mispredict),
      .head_data (head_entry),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         update_enable      <= 1'b0;
         update_index       <= '0;
         update_taken       <= 1'b0;
         update_is_rollback <= 1'b0;
         flush              <= 1'b0;
         error              <= 1'b0;
      end else begin
         update_enable      <= pop;
         update_index       <= pop ? head_entry.index : '0;
         update_taken       <= pop && resolve_taken;
         update_is_rollback <= mispredict;
         flush              <= mispredict;
         if ((push && full && !pop) || (resolve_valid && empty)) error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_branch_outcome_tracker.sv
// Randomised and directed bench for branch_outcome_tracker against a queue-based model.
module tb_branch_outcome_tracker;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned IW    = 8;
   localparam int unsigned CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          reset;
   logic          is_stalling, query_valid, predicted_take, resolve_valid, resolve_taken;
   logic [IW-1:0] query_index;
   logic          update_enable, update_taken, update_is_rollback, flush;
   logic [IW-1:0] update_index;
   logic [CW-1:0] count;
   logic          full, empty, error;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: queue of {index, predicted_take} in program order.
   int mq[$];
   bit m_err;
   bit e_upd, e_taken, e_rb;
   int e_idx;

   branch_outcome_tracker #(
      .DEPTH     (DEPTH),
      .INDEX_LEN (IW)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .is_stalling        (is_stalling),
      .query_valid        (query_valid),
      .query_index        (query_index),
      .predicted_take     (predicted_take),
      .resolve_valid      (resolve_valid),
      .resolve_taken      (resolve_taken),
      .update_enable      (update_enable),
      .update_index       (update_index),
      .update_taken       (update_taken),
      .update_is_rollback (update_is_rollback),
      .flush              (flush),
      .count              (count),
      .full               (full),
      .empty              (empty),
      .error              (error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_state();
      check("update_enable", 32'(update_enable), 32'(e_upd));
      if (e_upd) begin
         check("update_index", 32'(update_index), 32'(e_idx));
         check("update_taken", 32'(update_taken), 32'(e_taken));
      end
      check("update_is_rollback", 32'(update_is_rollback), 32'(e_rb));
      check("flush", 32'(flush), 32'(e_rb));
      check("count", 32'(count), 32'(mq.size()));
      check("full", 32'(full), 32'(mq.size() == DEPTH));
      check("empty", 32'(empty), 32'(mq.size() == 0));
      check("error", 32'(error), 32'(m_err));
   endtask

   function automatic bit head_take();
      return (mq.size() > 0) ? mq[0][0] : 1'b0;
   endfunction

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic step(input bit qv, input int qi, input bit pt, input bit st,
                       input bit rv, input bit rt);
      bit p;
      int ent;
      query_valid    = qv;
      query_index    = IW'(qi);
      predicted_take = pt;
      is_stalling    = st;
      resolve_valid  = rv;
      resolve_taken  = rt;
      p     = qv && !st;
      e_upd = 0; e_rb = 0; e_taken = 0; e_idx = 0;
      if (rv && mq.size() == 0) begin
         m_err = 1;
         if (p) mq.push_back(qi * 2 + int'(pt));
      end else if (rv) begin
         ent     = mq.pop_front();
         e_upd   = 1;
         e_idx   = ent >> 1;
         e_taken = rt;
         e_rb    = (ent[0] != rt);
         if (e_rb) mq.delete();
         else if (p) mq.push_back(qi * 2 + int'(pt));
      end else if (p) begin
         if (mq.size() == DEPTH) m_err = 1;
         else mq.push_back(qi * 2 + int'(pt));
      end
      @(posedge clk);
      #1;
      check_state();
      @(negedge clk);
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      query_valid = 0; is_stalling = 0; resolve_valid = 0;
      resolve_taken = 0; predicted_take = 0; query_index = '0;
      mq.delete();
      m_err = 0; e_upd = 0; e_rb = 0; e_taken = 0; e_idx = 0;
      @(negedge clk);
      check_state();
      check("rst_update_index", 32'(update_index), 32'd0);
      check("rst_update_taken", 32'(update_taken), 32'd0);
      reset = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      @(negedge clk);
      do_reset();

      // Three pushes, then three taken resolves; idx 5 mispredicts and flushes.
      step(1, 3, 1, 0, 0, 0);
      step(1, 5, 0, 0, 0, 0);
      step(1, 7, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 1);

      // Fill, overflow, then a correct resolve of idx 0.
      do_reset();
      for (int i = 0; i < DEPTH; i++) step(1, i, 1, 0, 0, 0);
      step(1, 99, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1, 1);

      // Push coinciding with a head mispredict is discarded without error.
      do_reset();
      for (int i = 0; i < 4; i++) step(1, 20 + i, 0, 0, 0, 0);
      step(1, 9, 1, 0, 1, 1);

      // Stall blocks pushes but not resolves.
      do_reset();
      step(1, 40, 1, 0, 0, 0);
      step(1, 41, 1, 0, 0, 0);
      step(1, 50, 1, 1, 0, 0);
      step(1, 51, 1, 1, 1, 1);
      step(1, 52, 1, 1, 0, 0);

      // 12 pushes and 12 correct pops overlapping, wrapping the pointers.
      do_reset();
      for (int i = 0; i < 4; i++) step(1, 60 + i, i[0], 0, 0, 0);
      for (int i = 4; i < 12; i++) step(1, 60 + i, i[0], 0, 1, head_take());
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, head_take());

      // Randomised traffic, biased towards correct predictions so the buffer fills.
      for (int blk = 0; blk < 4; blk++) begin
         do_reset();
         for (int i = 0; i < 150; i++) begin
            bit rv, rt;
            rv = ($urandom_range(0, 9) < 4);
            rt = (mq.size() > 0 && $urandom_range(0, 7) != 0) ? head_take()
                                                               : 1'($urandom_range(0, 1));
            step(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0), rv, rt);
         end
      end

      // Asynchronous reset between edges while an update pulse is live.
      do_reset();
      step(1, 77, 1, 0, 0, 0);
      step(1, 78, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1, 1);
      #2;
      reset = 1'b1;
      #1;
      check("async_update_enable", 32'(update_enable), 32'd0);
      check("async_update_index", 32'(update_index), 32'd0);
      check("async_update_taken", 32'(update_taken), 32'd0);
      check("async_count", 32'(count), 32'd0);
      check("async_empty", 32'(empty), 32'd1);
      check("async_error", 32'(error), 32'd0);
      reset = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
